vec_mem_sequencer: RTL and testbench

VEC_MEM_SEQUENCER -- requirements
Module: vec_mem_sequencer

---
 rtl/vec_mem_sequencer.sv | 113 +++++++++++
 tb/tb_vec_mem_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/vec_mem_sequencer.sv
// vec_mem_sequencer: moves one 16-element x 16-bit vector between a vector
// register and word memory, one element per accepted memory request.
// Ports:
//   clk, rst_n           - clock, async active-low reset
//   start, is_store      - transfer request pulse and direction (1 = VST)
//   base_addr, offset    - start address = base_addr + sext(offset)
//   st_data / ld_data    - store source / load result, element i at [16i+15:16i]
//   busy, done           - transfer active / one-cycle completion pulse
//   mem_req..mem_wdata   - memory request channel (held until mem_ack)
//   mem_rdata, mem_ack   - memory response
module vec_mem_sequencer (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         is_store,
    input  logic [15:0]  base_addr,
    input  logic [5:0]   offset,
    input  logic [255:0] st_data,
    output logic         busy,
    output logic         done,
    output logic [255:0] ld_data,
    output logic         mem_req,
    output logic         mem_we,
    output logic [15:0]  mem_addr,
    output logic [15:0]  mem_wdata,
    input  logic [15:0]  mem_rdata,
    input  logic         mem_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [3:0]     idx_q, idx_d;
    logic [15:0]    addr_q, addr_d;
    logic           we_q, we_d;
    logic [255:0]   st_q, st_d;
    logic [255:0]   ld_q, ld_d;
    logic [7:0]     bit_pos;

    assign bit_pos = {idx_q, 4'b0000};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        we_d    = we_q;
        st_d    = st_q;
        ld_d    = ld_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = XFER;
                    we_d    = is_store;
                    st_d    = st_data;
                    addr_d  = base_addr + {{10{offset[5]}}, offset};
                    idx_d   = 4'd0;
                end
            end
            XFER: begin
                if (mem_ack) begin
                    if (!we_q) begin
                        ld_d[bit_pos +: 16] = mem_rdata;
                    end
                    if (idx_q == 4'd15) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            DONE: begin
                // start is deliberately not sampled here: no queuing.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            addr_q  <= 16'd0;
            we_q    <= 1'b0;
            st_q    <= 256'd0;
            ld_q    <= 256'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            st_q    <= st_d;
            ld_q    <= ld_d;
        end
    end

    // Request fields are pure decodes of held state, so they stay stable
    // for as long as the memory withholds mem_ack.
    assign mem_req   = (state_q == XFER);
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = mem_req ? (addr_q + {12'd0, idx_q}) : 16'd0;
    assign mem_wdata = mem_we ? st_q[bit_pos +: 16] : 16'd0;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign ld_data   = ld_q;

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// tb_vec_mem_sequencer: directed table-driven bench for vec_mem_sequencer
// plus hand-written reset-abort and idle-ack sequences.
module tb_vec_mem_sequencer;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         is_store;
    logic [15:0]  base_addr;
    logic [5:0]   offset;
    logic [255:0] st_data;
    logic         busy;
    logic         done;
    logic [255:0] ld_data;
    logic         mem_req;
    logic         mem_we;
    logic [15:0]  mem_addr;
    logic [15:0]  mem_wdata;
    logic [15:0]  mem_rdata;
    logic         mem_ack;

    int checks;
    int errors;
    logic [255:0] ld_model;

    typedef struct {
        logic        st;
        logic [15:0] base;
        logic [5:0]  off;
        logic [15:0] a0;
        int          stall_idx;
        int          stall_n;
        logic        pulse;
    } vec_t;

    vec_t tbl [6];

    vec_mem_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_store  (is_store),
        .base_addr (base_addr),
        .offset    (offset),
        .st_data   (st_data),
        .busy      (busy),
        .done      (done),
        .ld_data   (ld_data),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic run_xfer(input vec_t v);
        int          cyc;
        int          idx;
        int          waitc;
        int          exp_done;
        logic [15:0] ea;
        logic [255:0] sd;
        for (int i = 0; i < 16; i++) begin
            sd[16*i +: 16] = v.st ? 16'(i) : 16'h5500 + 16'(i);
        end
        exp_done = 17 + ((v.stall_idx >= 0) ? v.stall_n : 0);
        start     = 1'b1;
        is_store  = v.st;
        base_addr = v.base;
        offset    = v.off;
        st_data   = sd;
        mem_ack   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        st_data = ~sd;
        cyc   = 1;
        idx   = 0;
        waitc = 0;
        while (idx < 16 && cyc < 100) begin
            ea = v.a0 + 16'(idx);
            chk("xfer_req", 256'(mem_req), 256'(1'b1));
            chk("xfer_busy", 256'(busy), 256'(1'b1));
            chk("xfer_done", 256'(done), 256'(1'b0));
            chk("xfer_addr", 256'(mem_addr), 256'(ea));
            chk("xfer_we", 256'(mem_we), 256'(v.st));
            chk("xfer_wdata", 256'(mem_wdata),
                256'(v.st ? 16'(idx) : 16'h0000));
            mem_ack   = !(idx == v.stall_idx && waitc < v.stall_n);
            mem_rdata = 16'hA000 + ea;
            if (v.pulse && cyc == 4) begin
                start    = 1'b1;
                is_store = ~v.st;
            end
            @(negedge clk);
            start = 1'b0;
            if (mem_ack) begin
                if (!v.st) ld_model[16*idx +: 16] = 16'hA000 + ea;
                idx++;
                waitc = 0;
            end else begin
                waitc++;
            end
            cyc++;
        end
        chk("done_cycle", 256'(cyc), 256'(exp_done));
        chk("done_pulse", 256'(done), 256'(1'b1));
        chk("done_busy", 256'(busy), 256'(1'b1));
        chk("done_req", 256'(mem_req), 256'(1'b0));
        chk("done_addr", 256'(mem_addr), 256'(16'h0000));
        chk("done_wdata", 256'(mem_wdata), 256'(16'h0000));
        if (v.pulse) start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        mem_ack = 1'b0;
        chk("idle_busy", 256'(busy), 256'(1'b0));
        chk("idle_done", 256'(done), 256'(1'b0));
        chk("ld_data", ld_data, ld_model);
        @(negedge clk);
        chk("idle_req", 256'(mem_req), 256'(1'b0));
        chk("idle_busy2", 256'(busy), 256'(1'b0));
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        ld_model  = '0;
        rst_n     = 1'b0;
        start     = 1'b0;
        is_store  = 1'b0;
        base_addr = '0;
        offset    = '0;
        st_data   = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;

        tbl[0] = '{1'b0, 16'h0100, 6'b111110, 16'h00FE, -1, 0, 1'b0};
        tbl[1] = '{1'b1, 16'hFFFC, 6'b000000, 16'hFFFC, -1, 0, 1'b0};
        tbl[2] = '{1'b0, 16'hFFF8, 6'b011111, 16'h0017, -1, 0, 1'b0};
        tbl[3] = '{1'b0, 16'h0005, 6'b100000, 16'hFFE5, -1, 0, 1'b0};
        tbl[4] = '{1'b0, 16'h2000, 6'b000011, 16'h2003, 5, 3, 1'b0};
        tbl[5] = '{1'b1, 16'h0040, 6'b000001, 16'h0041, -1, 0, 1'b1};

        repeat (2) @(negedge clk);
        chk("rst_busy", 256'(busy), 256'(1'b0));
        chk("rst_req", 256'(mem_req), 256'(1'b0));
        chk("rst_ld", ld_data, 256'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Spurious acks while idle must change nothing.
        mem_ack   = 1'b1;
        mem_rdata = 16'hFFFF;
        repeat (3) begin
            @(negedge clk);
            chk("spur_busy", 256'(busy), 256'(1'b0));
            chk("spur_req", 256'(mem_req), 256'(1'b0));
            chk("spur_ld", ld_data, ld_model);
        end
        mem_ack = 1'b0;

        for (int k = 0; k < 6; k++) begin
            run_xfer(tbl[k]);
        end

        // Abort a load after element 7 has been acknowledged.
        start     = 1'b1;
        is_store  = 1'b0;
        base_addr = 16'h0300;
        offset    = 6'b000000;
        mem_ack   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            mem_rdata = 16'hB000 + 16'(i);
            @(negedge clk);
        end
        chk("pre_abort_addr", 256'(mem_addr), 256'(16'h0308));
        mem_ack = 1'b0;
        rst_n   = 1'b0;
        ld_model = '0;
        #1;
        chk("abort_busy", 256'(busy), 256'(1'b0));
        chk("abort_done", 256'(done), 256'(1'b0));
        chk("abort_req", 256'(mem_req), 256'(1'b0));
        chk("abort_we", 256'(mem_we), 256'(1'b0));
        chk("abort_addr", 256'(mem_addr), 256'(16'h0000));
        chk("abort_wdata", 256'(mem_wdata), 256'(16'h0000));
        chk("abort_ld", ld_data, ld_model);
        @(negedge clk);
        rst_n   = 1'b1;
        mem_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_req", 256'(mem_req), 256'(1'b0));
            chk("post_rst_busy", 256'(busy), 256'(1'b0));
        end
        mem_ack = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
